mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Iterative multiply sequencer for the execute stage. It accepts one MUL/MLA request per operation and latches the operands. It then runs a radix-4 (2 multiplier bits per cycle) shift-add datapath with early termination. It stalls the pipeline while busy and presents a held result with N/Z flags until the downstream stage accepts it. The execute stage merges those flags into CPSR as C=0 with V preserved, and writes the result to Rd.

## Interface
Parameters:
- `WIDTH`, default 32: operand, accumulator and result width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `Nrst` in 1: reset, asynchronous and active-low.
- `req` in 1: start request; sampled only in IDLE.
- `flush` in 1: abort current operation; overrides `req`.
- `stall` in 1: downstream stall; holds result in DONE.
- `acc_en` in 1: MLA; accumulate `acc0`, else start from 0.
- `setflags` in 1: S bit; captured with request.
- `rd` in 4: destination register; captured with request.
- `acc0` in WIDTH: accumulate operand (Rn).
- `rm` in WIDTH: multiplier, consumed 2 bits per cycle.
- `rs` in WIDTH: multiplicand.
- `outstall` out 1: pipeline stall request (combinational).
- `busy` out 1: state != IDLE.
- `done` out 1: result valid (registered state decode).
- `result` out WIDTH: product + accumulator, mod 2^WIDTH.
- `rd_out` out 4: captured Rd.
- `setflags_out` out 1: captured S.
- `flag_n` out 1: `result[WIDTH-1]`.
- `flag_z` out 1: `result == 0`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `req & !flush` latches `bitfield<=rm`, `mcand<=rs`, `acc<=acc_en?acc0:0`, `rd`, `setflags`.
  - Next state is RUN.
- RUN with `bitfield!=0`:
  - `acc += (bitfield[0]?mcand:0) + (bitfield[1]?mcand<<1:0)`.
  - `bitfield>>=2`, `mcand<<=2`.
- RUN with `bitfield==0`: `result<=acc`; next state is DONE.
- DONE:
  - `done=1`; `result`, `rd_out`, `setflags_out` and flags are held.
  - `!stall` returns to IDLE; `stall` stays in DONE.
- All sums are truncated to WIDTH; no carry-out is kept.
- `flush` in any state: next state IDLE, `done` deasserts next cycle, no result is delivered.
- `req` outside IDLE is ignored. It is a protocol error and must not disturb the operation in flight.
- `Nrst` low, at any time including mid-RUN: immediate return to IDLE.
- `outstall = (IDLE & req & !flush) | RUN | (DONE & stall)`.

## Timing
- Request is accepted at the end of cycle T.
- Define n = 0 if `rm==0`, else `floor(msb(rm)/2)+1`. `done` first asserts in cycle T+2+n.
  - Minimum latency T+2 (`rm==0`).
  - Maximum latency T+18 (`rm[31]` set, WIDTH=32).
- `done` stays high for 1 cycle if `stall` is low, else until the first cycle with `stall` low, inclusive.
- The earliest next accept is the cycle after DONE exits, so throughput is one operation per n+3 cycles.
- Flags are derived combinationally from the registered `result`, so they are valid whenever `done` is high.
- Reset values:
  - State IDLE.
  - `busy`, `done`, `outstall` (given `req=0`) = 0.
  - `result`, `rd_out`, `setflags_out` = 0.
  - `flag_n` = 0, `flag_z` = 1 (derived from `result=0`).
  - Internal `acc`, `bitfield`, `mcand` = 0.

## Structure
- Shared package holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - MUL decode field positions (A=bit 21, S=bit 20, Rd=19:16, Rn=15:12, Rs=11:8, Rm=3:0) so the execute stage and this block agree.
  - The CPSR flag bit indices.
- One sub-module, `mult_datapath`: the `bitfield`/`mcand`/`acc` registers plus the radix-4 adder, controlled by `load` and `step` strobes from this FSM. The FSM and handshake stay in `mult_sequencer`.

## Test plan
- MLA: `rm=7`, `rs=6`, `acc_en=1`, `acc0=5`, `rd=3`.
  - `result=47`, `rd_out=3`, N=0, Z=0.
  - `done` at T+4; `outstall` high from T through T+3.
- `rm=0`, `rs=0x1234`: `done` at T+2, `result=0`, Z=1.
- `rm=rs=0xFFFFFFFF`, `acc_en=0`: `result=1`, `done` at T+18, N=0.
- `rm=0x80000000`, `rs=2`: `result=0`, Z=1, `done` at T+18. Checks truncation.
- `flush` at T+3 of a `rm=0xFFFF` run:
  - IDLE at T+4, `done` never asserts.
  - A new `req` at T+4 is accepted and produces the correct result.
- Stall and reset:
  - `stall` held 3 cycles in DONE: `done` and `result` stable for 4 cycles, `outstall` high during the stall, IDLE after release.
  - `Nrst` pulsed mid-RUN: all outputs take their reset values immediately.
  - A `req` during RUN does not change `result`.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mult_sequencer_pkg
// Shared definitions for the iterative multiply sequencer and the execute
// stage that feeds it.
//   - state_t          : sequencer FSM encoding (IDLE/RUN/DONE)
//   - MUL_*            : MUL/MLA instruction field positions, so the decoder
//                        and this block agree on where A, S, Rd, Rn, Rs, Rm sit
//   - CPSR_*           : CPSR flag bit indices used when merging N/Z
//   - REG_IDX_W        : width of a register index (Rd)
// -----------------------------------------------------------------------------
package mult_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int REG_IDX_W = 4;

    // MUL/MLA encoding field positions
    localparam int MUL_A_BIT   = 21;
    localparam int MUL_S_BIT   = 20;
    localparam int MUL_RD_MSB  = 19;
    localparam int MUL_RD_LSB  = 16;
    localparam int MUL_RN_MSB  = 15;
    localparam int MUL_RN_LSB  = 12;
    localparam int MUL_RS_MSB  = 11;
    localparam int MUL_RS_LSB  = 8;
    localparam int MUL_RM_MSB  = 3;
    localparam int MUL_RM_LSB  = 0;

    // CPSR condition flag positions
    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

endpackage

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
// Radix-4 shift-add multiply datapath. Holds the remaining multiplier bits
// (bitfield), the shifted multiplicand (mcand) and the running sum (acc).
// Ports:
//   clk, Nrst      : clock, asynchronous active-low reset
//   load           : capture rm/rs/acc_init for a new operation
//   step           : consume two multiplier bits and add the partial product
//   rm, rs         : multiplier / multiplicand
//   acc_init       : starting accumulator value (Rn for MLA, 0 for MUL)
//   acc            : running sum (final product once bitfield_zero)
//   bitfield_zero  : no multiplier bits remain, so the sum is final
// -----------------------------------------------------------------------------
module mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Nrst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] acc_init,
    output logic [WIDTH-1:0] acc,
    output logic             bitfield_zero
);

    logic [WIDTH-1:0] bitfield;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] partial;

    // Partial product for the two low multiplier bits: 0, 1x, 2x or 3x mcand.
    // Everything wraps at WIDTH, matching the architectural mod-2^WIDTH result.
    always_comb begin
        partial = '0;
        if (bitfield[0]) partial = partial + mcand;
        if (bitfield[1]) partial = partial + (mcand << 1);
    end

    assign bitfield_zero = (bitfield == '0);

    // Early termination falls out naturally: once the upper multiplier bits
    // are exhausted bitfield reads zero and the FSM stops issuing steps.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            bitfield <= '0;
            mcand    <= '0;
            acc      <= '0;
        end else if (load) begin
            bitfield <= rm;
            mcand    <= rs;
            acc      <= acc_init;
        end else if (step) begin
            acc      <= acc + partial;
            bitfield <= bitfield >> 2;
            mcand    <= mcand << 2;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
// Iterative MUL/MLA sequencer for the execute stage. Accepts one request in
// IDLE, runs the radix-4 datapath until the multiplier is exhausted, then
// holds the result with N/Z flags in DONE until downstream stops stalling.
// Ports:
//   clk, Nrst      : clock, asynchronous active-low reset
//   req            : start request (only looked at in IDLE)
//   flush          : abort whatever is in flight, wins over req
//   stall          : downstream not ready, keeps DONE
//   acc_en         : MLA (start from acc0) vs MUL (start from 0)
//   setflags, rd   : S bit and destination, captured with the request
//   acc0, rm, rs   : accumulate operand, multiplier, multiplicand
//   outstall       : stall request to the pipeline (combinational)
//   busy, done     : not idle / result valid
//   result         : product + accumulator, mod 2^WIDTH
//   rd_out, setflags_out : captured Rd / S
//   flag_n, flag_z : N and Z derived from result
// -----------------------------------------------------------------------------
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 Nrst,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 acc_en,
    input  logic                 setflags,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [WIDTH-1:0]     acc0,
    input  logic [WIDTH-1:0]     rm,
    input  logic [WIDTH-1:0]     rs,
    output logic                 outstall,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [REG_IDX_W-1:0] rd_out,
    output logic                 setflags_out,
    output logic                 flag_n,
    output logic                 flag_z
);

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             step;
    logic             capture;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_init;
    logic             bitfield_zero;

    assign acc_init = acc_en ? acc0 : '0;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk           (clk),
        .Nrst          (Nrst),
        .load          (load),
        .step          (step),
        .rm            (rm),
        .rs            (rs),
        .acc_init      (acc_init),
        .acc           (acc),
        .bitfield_zero (bitfield_zero)
    );

    // Next-state and strobes. flush is checked first in every busy state so
    // an abort never lets a step or result capture slip through.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        outstall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && !flush) begin
                    load       = 1'b1;
                    outstall   = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                outstall = 1'b1;
                if (flush) begin
                    next_state = ST_IDLE;
                end else if (!bitfield_zero) begin
                    step = 1'b1;
                end else begin
                    capture    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                outstall = stall;
                if (flush || !stall) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State plus the architectural outputs. result is only rewritten on a
    // completed operation, so a flushed or reset run never leaks a value.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state        <= ST_IDLE;
            result       <= '0;
            rd_out       <= '0;
            setflags_out <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                rd_out       <= rd;
                setflags_out <= setflags;
            end
            if (capture) begin
                result <= acc;
            end
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign flag_n = result[WIDTH-1];
    assign flag_z = (result == '0);

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
// Self-checking bench for mult_sequencer (WIDTH=32). Stimulus pushes the
// expected result into a scoreboard; a negedge monitor pops and compares
// whenever done rises and keeps comparing while done is held.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        sf;
    } exp_item_t;

    logic        clk = 1'b0;
    logic        Nrst = 1'b0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        acc_en = 1'b0;
    logic        setflags = 1'b0;
    logic [3:0]  rd = '0;
    logic [31:0] acc0 = '0;
    logic [31:0] rm = '0;
    logic [31:0] rs = '0;
    logic        outstall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  rd_out;
    logic        setflags_out;
    logic        flag_n;
    logic        flag_z;

    int          tests = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_item_t   sb[$];
    exp_item_t   cur;
    bit          have = 0;
    logic        prev_done = 1'b0;

    mult_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .Nrst         (Nrst),
        .req          (req),
        .flush        (flush),
        .stall        (stall),
        .acc_en       (acc_en),
        .setflags     (setflags),
        .rd           (rd),
        .acc0         (acc0),
        .rm           (rm),
        .rs           (rs),
        .outstall     (outstall),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .setflags_out (setflags_out),
        .flag_n       (flag_n),
        .flag_z       (flag_z)
    );

    // Free-running clock and a cycle counter for latency measurements
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide arithmetic, truncated to 32 bits
    function automatic logic [31:0] model_result(logic [31:0] m, logic [31:0] s,
                                                 logic [31:0] a, logic en);
        logic [63:0] p;
        p = 64'(m) * 64'(s) + (en ? 64'(a) : 64'd0);
        return p[31:0];
    endfunction

    // Number of radix-4 steps: one per pair of bits up to the top set bit
    function automatic int model_steps(logic [31:0] m);
        int hi;
        if (m == '0) return 0;
        hi = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hi = i;
        return hi / 2 + 1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: pop on the rising edge of done, then compare the
    // held outputs on every cycle done stays high
    always @(negedge clk) begin
        if (Nrst && done) begin
            if (!prev_done) begin
                if (sb.size() == 0) begin
                    tests++;
                    failures++;
                    have = 0;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
                end else begin
                    cur  = sb.pop_front();
                    have = 1;
                end
            end
            if (have) begin
                check_output("result", result, cur.result);
                check_output("rd_out", 32'(rd_out), 32'(cur.rd));
                check_output("setflags_out", 32'(setflags_out), 32'(cur.sf));
                check_output("flag_n", 32'(flag_n), 32'(cur.result[31]));
                check_output("flag_z", 32'(flag_z), 32'(cur.result == 32'd0));
            end
        end else begin
            have = 0;
        end
        prev_done = Nrst ? done : 1'b0;
    end

    // Issues one operation in the current cycle (DUT idle, time = posedge+1),
    // checks outstall/latency, walks the DONE handshake with stall_cycles of
    // stall, optionally pokes a stray req during RUN.
    task automatic apply_stimulus(input logic [31:0] a_rm, input logic [31:0] a_rs,
                                  input logic [31:0] a_acc0, input logic a_acc_en,
                                  input logic [3:0] a_rd, input logic a_sf,
                                  input int stall_cycles, input bit poke);
        exp_item_t item;
        int        t0;
        int        waited;
        int        exp_lat;
        bit        seen;
        item.result = model_result(a_rm, a_rs, a_acc0, a_acc_en);
        item.rd     = a_rd;
        item.sf     = a_sf;
        exp_lat     = 2 + model_steps(a_rm);
        sb.push_back(item);
        rm = a_rm; rs = a_rs; acc0 = a_acc0; acc_en = a_acc_en;
        rd = a_rd; setflags = a_sf;
        req   = 1'b1;
        stall = (stall_cycles > 0);
        t0    = cyc;
        #1 check_output("outstall_accept", 32'(outstall), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        // Scramble the operand inputs to prove they were latched
        rm = $urandom; rs = $urandom; acc0 = $urandom;
        rd = 4'($urandom); acc_en = 1'($urandom); setflags = 1'($urandom);
        waited = 0;
        seen   = 0;
        while (!seen && waited < 40) begin
            if (done) begin
                seen = 1;
            end else begin
                check_output("outstall_run", 32'(outstall), 32'd1);
                if (poke && cyc == t0 + 2) begin
                    req = 1'b1; rm = $urandom; rs = $urandom; acc0 = $urandom;
                    rd = 4'($urandom); acc_en = 1'b1;
                end else begin
                    req = 1'b0;
                end
                @(posedge clk); #1;
                waited++;
            end
        end
        req = 1'b0;
        if (!seen) begin
            tests++;
            failures++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done at +%0d", waited, exp_lat);
            stall = 1'b0;
            return;
        end
        check_output("latency", 32'(cyc - t0), 32'(exp_lat));
        for (int k = 0; k <= stall_cycles; k++) begin
            check_output("done_hold", 32'(done), 32'd1);
            if (k < stall_cycles) begin
                stall = 1'b1;
                #1 check_output("outstall_stall", 32'(outstall), 32'd1);
            end else begin
                stall = 1'b0;
                #1 check_output("outstall_release", 32'(outstall), 32'd0);
            end
            @(posedge clk); #1;
        end
        check_output("done_exit", 32'(done), 32'd0);
        check_output("busy_exit", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] r_rm;
        int          t0;

        // Reset values
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_outstall", 32'(outstall), 32'd0);
        check_output("rst_result", result, 32'd0);
        check_output("rst_rd_out", 32'(rd_out), 32'd0);
        check_output("rst_setflags_out", 32'(setflags_out), 32'd0);
        check_output("rst_flag_n", 32'(flag_n), 32'd0);
        check_output("rst_flag_z", 32'(flag_z), 32'd1);
        @(posedge clk); #1;
        Nrst = 1'b1;
        @(posedge clk); #1;

        // Directed cases: MLA, zero multiplier, all-ones, truncation
        apply_stimulus(32'd7, 32'd6, 32'd5, 1'b1, 4'd3, 1'b1, 0, 0);
        apply_stimulus(32'd0, 32'h1234, 32'h55, 1'b0, 4'd9, 1'b0, 0, 0);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h77, 1'b0, 4'd1, 1'b1, 0, 0);
        apply_stimulus(32'h8000_0000, 32'd2, 32'd0, 1'b0, 4'd2, 1'b1, 0, 0);

        // Flush at T+3 of a 0xFFFF run, new request at T+4
        rm = 32'hFFFF; rs = 32'h1357; acc0 = 32'd0; acc_en = 1'b0; rd = 4'd5; req = 1'b1;
        t0 = cyc;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_output("flush_cycle", 32'(cyc - t0), 32'd4);
        check_output("flush_busy", 32'(busy), 32'd0);
        check_output("flush_done", 32'(done), 32'd0);
        apply_stimulus(32'h0000_0123, 32'h0004_5678, 32'h10, 1'b1, 4'd6, 1'b0, 0, 0);

        // Stall held for 3 cycles in DONE
        apply_stimulus(32'h0000_00A5, 32'h0000_1111, 32'd3, 1'b1, 4'd7, 1'b1, 3, 0);

        // Stray req during RUN must not disturb the operation
        apply_stimulus(32'h00F0_0000, 32'h0000_0321, 32'd9, 1'b1, 4'd8, 1'b0, 0, 1);

        // Leave a nonzero result, then reset mid-RUN
        apply_stimulus(32'd3, 32'd5, 32'd0, 1'b0, 4'd4, 1'b1, 0, 0);
        rm = 32'h00FF_FFFF; rs = 32'h0000_0777; acc_en = 1'b0; rd = 4'hC; setflags = 1'b1; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        Nrst = 1'b0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        check_output("mid_rst_outstall", 32'(outstall), 32'd0);
        check_output("mid_rst_result", result, 32'd0);
        check_output("mid_rst_rd_out", 32'(rd_out), 32'd0);
        check_output("mid_rst_setflags_out", 32'(setflags_out), 32'd0);
        check_output("mid_rst_flag_n", 32'(flag_n), 32'd0);
        check_output("mid_rst_flag_z", 32'(flag_z), 32'd1);
        @(posedge clk); #1;
        Nrst = 1'b1;
        @(posedge clk); #1;

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            r_rm = $urandom;
            r_rm = r_rm >> $urandom_range(0, 32);
            apply_stimulus(r_rm, $urandom, $urandom, 1'($urandom), 4'($urandom),
                           1'($urandom), $urandom_range(0, 2), 0);
        end

        repeat (3) @(posedge clk);
        #1 check_output("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
